// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry holding register with valid/ready handshake and error pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_r, next_state_s;
  logic [TW-1:0]        timer_r, next_timer_s;
  logic [IW-1:0]        idx_r, next_idx_s;
  logic [DATA_BITS-1:0] shift_r, next_shift_s;
  logic [1:0]           sync_r;
  logic                 rx_s;
  logic                 complete_s;
  logic                 stop_low_s;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  assign rx_s = sync_r[1];

  // Input synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Receiver state, bit timer, bit index and data shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= '0;
      idx_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= next_state_s;
      timer_r <= next_timer_s;
      idx_r   <= next_idx_s;
      shift_r <= next_shift_s;
    end
  end

  // Next-state decode; complete_s/stop_low_s flag the stop-bit sample result.
  always_comb begin
    next_state_s = state_r;
    next_timer_s = timer_r + TW'(1);
    next_idx_s   = idx_r;
    next_shift_s = shift_r;
    complete_s   = 1'b0;
    stop_low_s   = 1'b0;
    case (state_r)
      IDLE: begin
        next_timer_s = '0;
        if (!rx_s) begin
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (timer_r == T_MID) begin
          next_timer_s = '0;
          next_idx_s   = '0;
          if (!rx_s) begin
            next_state_s = DATA;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (timer_r == T_LAST) begin
          next_timer_s = '0;
          next_shift_s = {rx_s, shift_r[DATA_BITS-1:1]};
          if (idx_r == I_LAST) begin
            next_idx_s   = '0;
            next_state_s = STOP;
          end else begin
            next_idx_s   = idx_r + IW'(1);
          end
        end else begin
          next_state_s = DATA;
        end
      end
      STOP: begin
        if (timer_r == T_LAST) begin
          next_timer_s = '0;
          if (rx_s) begin
            complete_s   = 1'b1;
            next_state_s = IDLE;
          end else begin
            stop_low_s   = 1'b1;
            next_state_s = BREAK;
          end
        end else begin
          next_state_s = STOP;
        end
      end
      BREAK: begin
        next_timer_s = '0;
        if (rx_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = BREAK;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_timer_s = '0;
        next_idx_s   = '0;
      end
    endcase
  end

  // Holding register: a handshake in the completion cycle frees the slot for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_low_s;
      overrun_r   <= 1'b0;
      if (complete_s) begin
        if (!rx_valid_r || rx_ready) begin
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r  <= 1'b1;
        end
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frame table, hand-written
// corner sequences and randomized frames against a frame-level model.
module tb_uart_rx_core;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk;
  logic          rst;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int ferr_cnt, ovr_cnt, valid_cycles;
  logic prev_valid, prev_hs, prev_ferr, prev_ovr;
  logic [7:0] prev_data;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    valid_cycles = 0;
  endtask

  function automatic int got_at(input int i);
    if (i < got_q.size()) return int'(got_q[i]);
    return -1;
  endfunction

  // Drives one 8N1 frame; a bad stop bit is held low for two bit times, then the line idles high.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(CPB);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_cycles(CPB);
    end else begin
      rx = 1'b0;
      wait_cycles(2 * CPB);
      rx = 1'b1;
      wait_cycles(CPB);
    end
  endtask

  // Output monitor: records handshaken bytes, counts pulses, checks pulse width and hold stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) begin
        ferr_cnt++;
        check("frame_err_width", int'(prev_ferr), 0);
      end
      if (overrun) begin
        ovr_cnt++;
        check("overrun_width", int'(prev_ovr), 0);
      end
      if (prev_valid && !prev_hs) begin
        check("hold_valid", int'(rx_valid), 1);
        check("hold_data", int'(rx_data), int'(prev_data));
      end
      prev_valid = rx_valid;
      prev_hs    = rx_valid && rx_ready;
      prev_data  = rx_data;
      prev_ferr  = frame_err;
      prev_ovr   = overrun;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_ferr  = 1'b0;
      prev_ovr   = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];
  bit   hold_valid;
  logic [7:0] hold_data;
  int   exp_ferr, exp_ovr;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1, 0};
    tbl[3] = '{8'h3C, 1'b0, 0, 1};
    tbl[4] = '{8'h81, 1'b1, 1, 0};
    tbl[5] = '{8'h7E, 1'b1, 1, 0};

    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    clear_mon();
    wait_cycles(3);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    wait_cycles(CPB);

    // Frame table, consumer always ready, frames sent back-to-back.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(tbl[i].data, tbl[i].stop_ok);
      check($sformatf("tbl%0d_bytes", i), got_q.size(), tbl[i].exp_bytes);
      if (tbl[i].exp_bytes > 0) check($sformatf("tbl%0d_data", i), got_at(0), int'(tbl[i].data));
      check($sformatf("tbl%0d_valid_cycles", i), valid_cycles, tbl[i].exp_bytes);
      check($sformatf("tbl%0d_frame_err", i), ferr_cnt, tbl[i].exp_ferr);
      check($sformatf("tbl%0d_overrun", i), ovr_cnt, 0);
    end

    // Short low glitch must be rejected.
    wait_cycles(CPB);
    clear_mon();
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_frame_err", ferr_cnt, 0);
    check("glitch_overrun", ovr_cnt, 0);

    // Long low stop bit, then a clean frame.
    clear_mon();
    send_frame(8'h3C, 1'b0);
    send_frame(8'h81, 1'b1);
    check("break_frame_err", ferr_cnt, 1);
    check("break_bytes", got_q.size(), 1);
    check("break_next_data", got_at(0), 8'h81);

    // Two frames while consumer stalls: overrun, first byte retained.
    rx_ready = 1'b0;
    wait_cycles(CPB);
    clear_mon();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_cycles(2);
    check("ovr_rx_valid", int'(rx_valid), 1);
    check("ovr_rx_data", int'(rx_data), 8'h3C);
    check("ovr_count", ovr_cnt, 1);
    rx_ready = 1'b1;
    wait_cycles(4);
    rx_ready = 1'b0;
    check("ovr_drain_bytes", got_q.size(), 1);
    check("ovr_drain_data", got_at(0), 8'h3C);
    check("ovr_drain_valid", int'(rx_valid), 0);

    // Reset in the middle of data bit 4 of 0x5A, then a clean 0x96.
    wait_cycles(CPB);
    clear_mon();
    begin
      logic [7:0] d;
      d = 8'h5A;
      rx = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 4; i++) begin
        rx = d[i];
        wait_cycles(CPB);
      end
      rx = d[4];
      wait_cycles(CPB / 2);
    end
    rst = 1'b1;
    rx = 1'b1;
    wait_cycles(4);
    check("midrst_rx_valid", int'(rx_valid), 0);
    rst = 1'b0;
    wait_cycles(2 * CPB);
    send_frame(8'h96, 1'b1);
    wait_cycles(2);
    check("midrst_rx_valid_after", int'(rx_valid), 1);
    check("midrst_rx_data", int'(rx_data), 8'h96);
    check("midrst_frame_err", ferr_cnt, 0);
    check("midrst_overrun", ovr_cnt, 0);
    rx_ready = 1'b1;
    wait_cycles(3);
    rx_ready = 1'b0;
    check("midrst_bytes", got_q.size(), 1);

    // Ready asserted exactly in the second byte's completion cycle.
    wait_cycles(CPB);
    clear_mon();
    fork
      begin
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
      end
      begin
        repeat (2 * 10 * CPB - 6) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    wait_cycles(2);
    check("same_cycle_overrun", ovr_cnt, 0);
    check("same_cycle_rx_valid", int'(rx_valid), 1);
    check("same_cycle_rx_data", int'(rx_data), 8'h34);
    rx_ready = 1'b1;
    wait_cycles(3);
    rx_ready = 1'b0;
    check("same_cycle_bytes", got_q.size(), 2);
    check("same_cycle_first", got_at(0), 8'h12);
    check("same_cycle_second", got_at(1), 8'h34);

    // Randomized frames against a single-slot holding model.
    wait_cycles(CPB);
    clear_mon();
    exp_q.delete();
    hold_valid = 1'b0;
    hold_data = 8'h00;
    exp_ferr = 0;
    exp_ovr = 0;
    for (int t = 0; t < 40; t++) begin
      logic [7:0] d;
      bit ok, rdy;
      int gap;
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      rdy = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      rx_ready = rdy;
      if (rdy && hold_valid) begin
        exp_q.push_back(hold_data);
        hold_valid = 1'b0;
      end
      send_frame(d, ok);
      if (!ok) exp_ferr++;
      else if (rdy) exp_q.push_back(d);
      else if (hold_valid) exp_ovr++;
      else begin
        hold_valid = 1'b1;
        hold_data = d;
      end
      rx = 1'b1;
      wait_cycles(gap * CPB + 2);
      check($sformatf("rnd%0d_bytes", t), got_q.size(), exp_q.size());
      check($sformatf("rnd%0d_frame_err", t), ferr_cnt, exp_ferr);
      check($sformatf("rnd%0d_overrun", t), ovr_cnt, exp_ovr);
    end
    rx_ready = 1'b1;
    if (hold_valid) exp_q.push_back(hold_data);
    wait_cycles(4);
    rx_ready = 1'b0;
    check("rnd_final_bytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rnd_byte%0d", i), got_at(i), int'(exp_q[i]));
    end
    check("rnd_final_valid", int'(rx_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit (legal: even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  serial line (idle high), asynchronous to clk.
REQ-006 SHALL have port rx_data  output  DATA_BITS  received byte, LSB = first data bit.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped, holding register full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, giving rx_s; all FSM decisions use rx_s only.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, plus a bit-timer counter and a bit index.
REQ-013 IDLE: on rx_s == 0 -> START, bit timer cleared.
REQ-014 START: at timer == CLKS_PER_BIT/2-1 (mid start bit), sample rx_s; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: sample rx_s each time timer reaches CLKS_PER_BIT-1, shift into the data register LSB-first, clear timer; after DATA_BITS samples -> STOP.
REQ-016 STOP: sample rx_s at timer == CLKS_PER_BIT-1; 1 -> byte complete, -> IDLE; 0 -> frame_err pulse, byte discarded, -> BREAK.
REQ-017 BREAK: remain until rx_s == 1, then -> IDLE; no new frame is detected while in BREAK.
REQ-018 Completed byte SHALL load rx_data and set rx_valid on the clock edge after the stop-bit sample.
REQ-019 rx_valid SHALL stay high, and rx_data stable, until a cycle with rx_valid && rx_ready; rx_valid then clears on the next edge.
REQ-020 Completion with rx_valid high and no handshake the same cycle: pulse overrun, drop the new byte, retain the old rx_data/rx_valid.
REQ-021 Completion in the same cycle as a handshake: load the new byte, keep rx_valid high, no overrun.
REQ-022 rx_ready while rx_valid is low SHALL have no effect.
REQ-023 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.
REQ-024 The receiver SHALL accept back-to-back frames: a start edge seen in IDLE directly after the stop sample is honoured.

Reset
REQ-025 While rst is high: FSM = IDLE, timer/index = 0, synchronizer flops = 1, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output; after release the block waits for a fresh falling edge on rx_s.

Verification
REQ-027 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit, rx_ready = 1 -> rx_valid pulses 1 cycle with rx_data = 0xA5, frame_err = overrun = 0.
REQ-028 rx low for 3 cycles, then high -> FSM returns to IDLE; rx_valid, frame_err and overrun stay 0.
REQ-029 Frame 0x3C with stop bit driven 0 for 2 bit times, then high -> single frame_err pulse, rx_valid stays 0, next frame 0x81 is received correctly.
REQ-030 Back-to-back frames 0x3C then 0xC3 with rx_ready = 0 -> rx_valid = 1 with rx_data = 0x3C, one overrun pulse at the second completion; asserting rx_ready then yields 0x3C only.
REQ-031 rst pulsed during data bit 4 of 0x5A, then a clean 0x96 frame -> no output for 0x5A; rx_data = 0x96, rx_valid set.
REQ-032 Two frames with rx_ready asserted exactly in the cycle the second byte completes -> both bytes delivered in order, overrun = 0.
